// File: rtl/design67_check_seq.sv
// design67_check_seq: on-chip self-check sequencer for golden/netlist
// equivalence runs. It holds the DUT pair in reset, checks the reset state,
// then drives NUM_VECTORS LFSR stimulus vectors. Each vector is compared
// SETTLE cycles after it is applied. Mismatches are counted with saturation.
//
// Optional feature: define CHECK_SEQ_FAIL_LOG_EN to add first-mismatch
// capture outputs (fail_valid, fail_idx, fail_golden, fail_netlist).
//
// Every output is registered. golden_out and netlist_out are sampled
// directly on the compare edge.

module design67_check_seq #(
    parameter int          IN_W        = 8,
    parameter int          OUT_W       = 32,
    parameter int          NUM_VECTORS = 1000,
    parameter int          SETTLE      = 2,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             dut_rst,
    output logic [IN_W-1:0]  stim_out,
    input  logic [OUT_W-1:0] golden_out,
    input  logic [OUT_W-1:0] netlist_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      mismatch_cnt,
    output logic [15:0]      vec_idx
`ifdef CHECK_SEQ_FAIL_LOG_EN
    ,
    output logic             fail_valid,
    output logic [15:0]      fail_idx,
    output logic [OUT_W-1:0] fail_golden,
    output logic [OUT_W-1:0] fail_netlist
`endif
);

    // A zero seed would lock the LFSR at zero, so it is replaced by 1.
    localparam logic [31:0] SEED_EFF    = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
    localparam int          SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST     = 3'd1,
        S_RST_CMP = 3'd2,
        S_RELEASE = 3'd3,
        S_VEC     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // One Galois step: shift right, fold the taps back in when bit 0 is set.
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        logic [31:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic               rst_cnt_r;
    logic [SET_W-1:0]   settle_cnt_r;
    logic [31:0]        lfsr_r;
    logic [31:0]        lfsr_nx_s;

    logic               clear_s;
    logic               seed_load_s;
    logic               advance_s;
    logic               compare_s;
    logic               diff_s;

    logic               dut_rst_r;
    logic [IN_W-1:0]    stim_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [15:0]        mismatch_cnt_r;
    logic [15:0]        vec_idx_r;

    logic               dut_rst_s;
    logic [IN_W-1:0]    stim_s;
    logic               busy_s;
    logic               done_s;
    logic [15:0]        mismatch_cnt_s;
    logic [15:0]        vec_idx_s;

    assign lfsr_nx_s = lfsr_step(lfsr_r);
    assign diff_s    = (golden_out != netlist_out);

    // Next-state logic and the per-cycle action strobes for the datapath.
    always_comb begin
        state_s     = state_r;
        clear_s     = 1'b0;
        seed_load_s = 1'b0;
        advance_s   = 1'b0;
        compare_s   = 1'b0;
        if (abort) begin
            state_s = S_IDLE;
            clear_s = 1'b1;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_s     = S_RST;
                        clear_s     = 1'b1;
                        seed_load_s = 1'b1;
                    end else begin
                        state_s = state_r;
                    end
                end
                S_RST: begin
                    if (rst_cnt_r) begin
                        state_s = S_RST_CMP;
                    end else begin
                        state_s = S_RST;
                    end
                end
                S_RST_CMP: begin
                    compare_s = 1'b1;
                    state_s   = S_RELEASE;
                end
                S_RELEASE: begin
                    // First vector load: nothing has been applied yet to compare.
                    advance_s = 1'b1;
                    state_s   = S_VEC;
                end
                S_VEC: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        compare_s = 1'b1;
                        if (vec_idx_r == LAST_IDX) begin
                            state_s = S_DONE;
                        end else begin
                            advance_s = 1'b1;
                            state_s   = S_VEC;
                        end
                    end else begin
                        state_s = S_VEC;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                    clear_s = 1'b1;
                end
            endcase
        end
    end

    // Next values of the counters and of the registered outputs.
    always_comb begin
        mismatch_cnt_s = mismatch_cnt_r;
        vec_idx_s      = vec_idx_r;
        if (clear_s) begin
            mismatch_cnt_s = 16'h0000;
            vec_idx_s      = 16'h0000;
        end else begin
            if (compare_s && diff_s && (mismatch_cnt_r != 16'hFFFF)) begin
                mismatch_cnt_s = mismatch_cnt_r + 16'd1;
            end else begin
                mismatch_cnt_s = mismatch_cnt_r;
            end
            // Only a VEC compare is followed by an advance; that moves the index.
            if (compare_s && advance_s) begin
                vec_idx_s = vec_idx_r + 16'd1;
            end else begin
                vec_idx_s = vec_idx_r;
            end
        end

        dut_rst_s = 1'b1;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        stim_s    = '0;
        case (state_s)
            S_IDLE: begin
                dut_rst_s = 1'b1;
                busy_s    = 1'b0;
            end
            S_RST, S_RST_CMP: begin
                dut_rst_s = 1'b1;
                busy_s    = 1'b1;
            end
            S_RELEASE: begin
                dut_rst_s = 1'b0;
                busy_s    = 1'b1;
            end
            S_VEC: begin
                dut_rst_s = 1'b0;
                busy_s    = 1'b1;
                if (advance_s) begin
                    stim_s = lfsr_nx_s[IN_W-1:0];
                end else begin
                    stim_s = stim_r;
                end
            end
            S_DONE: begin
                dut_rst_s = 1'b0;
                done_s    = 1'b1;
                stim_s    = stim_r;
            end
            default: begin
                dut_rst_s = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Sequencing counters: RST dwell, settle interval and the LFSR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_cnt_r    <= 1'b0;
            settle_cnt_r <= '0;
            lfsr_r       <= SEED_EFF;
        end else begin
            if ((state_r == S_RST) && (state_s == S_RST)) begin
                rst_cnt_r <= 1'b1;
            end else begin
                rst_cnt_r <= 1'b0;
            end
            if (advance_s) begin
                settle_cnt_r <= '0;
            end else if (state_r == S_VEC) begin
                settle_cnt_r <= settle_cnt_r + 1'b1;
            end else begin
                settle_cnt_r <= '0;
            end
            if (seed_load_s || clear_s) begin
                lfsr_r <= SEED_EFF;
            end else if (advance_s) begin
                lfsr_r <= lfsr_nx_s;
            end else begin
                lfsr_r <= lfsr_r;
            end
        end
    end

    // Registered outputs and result counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dut_rst_r      <= 1'b1;
            stim_r         <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            pass_r         <= 1'b0;
            mismatch_cnt_r <= 16'h0000;
            vec_idx_r      <= 16'h0000;
        end else begin
            dut_rst_r      <= dut_rst_s;
            stim_r         <= stim_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
            pass_r         <= done_s && (mismatch_cnt_s == 16'h0000);
            mismatch_cnt_r <= mismatch_cnt_s;
            vec_idx_r      <= vec_idx_s;
        end
    end

    assign dut_rst      = dut_rst_r;
    assign stim_out     = stim_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign pass         = pass_r;
    assign mismatch_cnt = mismatch_cnt_r;
    assign vec_idx      = vec_idx_r;

`ifdef CHECK_SEQ_FAIL_LOG_EN
    logic               fail_valid_r;
    logic [15:0]        fail_idx_r;
    logic [OUT_W-1:0]   fail_golden_r;
    logic [OUT_W-1:0]   fail_netlist_r;

    // First-mismatch capture; the reset compare is tagged with index 16'hFFFF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_valid_r   <= 1'b0;
            fail_idx_r     <= 16'h0000;
            fail_golden_r  <= '0;
            fail_netlist_r <= '0;
        end else if (clear_s) begin
            fail_valid_r   <= 1'b0;
            fail_idx_r     <= 16'h0000;
            fail_golden_r  <= '0;
            fail_netlist_r <= '0;
        end else if (compare_s && diff_s && !fail_valid_r) begin
            fail_valid_r   <= 1'b1;
            fail_idx_r     <= (state_r == S_RST_CMP) ? 16'hFFFF : vec_idx_r;
            fail_golden_r  <= golden_out;
            fail_netlist_r <= netlist_out;
        end else begin
            fail_valid_r   <= fail_valid_r;
            fail_idx_r     <= fail_idx_r;
            fail_golden_r  <= fail_golden_r;
            fail_netlist_r <= fail_netlist_r;
        end
    end

    assign fail_valid   = fail_valid_r;
    assign fail_idx     = fail_idx_r;
    assign fail_golden  = fail_golden_r;
    assign fail_netlist = fail_netlist_r;
`endif

endmodule

// File: tb/tb_design67_check_seq.sv
// Self-checking bench for design67_check_seq. The bench stands in for the
// golden/netlist pair and can plant faults in the netlist side. A
// reference model predicts the stimulus sequence, the timing of each
// event and the mismatch count.
module tb_design67_check_seq;

    localparam int          IN_W  = 8;
    localparam int          OUT_W = 32;
    localparam int          NV    = 1000;
    localparam int          ST    = 2;
    localparam logic [31:0] TAPS  = 32'h8020_0003;
    localparam logic [31:0] RST_GOLDEN = 32'hDEAD_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             dut_rst;
    logic [IN_W-1:0]  stim_out;
    logic [OUT_W-1:0] golden_out;
    logic [OUT_W-1:0] netlist_out;
    logic [OUT_W-1:0] fault_mask;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      mismatch_cnt;
    logic [15:0]      vec_idx;
`ifdef CHECK_SEQ_FAIL_LOG_EN
    logic             fail_valid;
    logic [15:0]      fail_idx;
    logic [OUT_W-1:0] fail_golden;
    logic [OUT_W-1:0] fail_netlist;
`endif

    int        n_cmp = 0;
    int        n_bad = 0;
    int        mode  = 0;
    bit        bad_tab [0:255];
    logic [7:0] exp_stim [NV];

    design67_check_seq #(
        .IN_W(IN_W), .OUT_W(OUT_W), .NUM_VECTORS(NV), .SETTLE(ST), .SEED(32'h1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_rst(dut_rst), .stim_out(stim_out),
        .golden_out(golden_out), .netlist_out(netlist_out),
        .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .vec_idx(vec_idx)
`ifdef CHECK_SEQ_FAIL_LOG_EN
        , .fail_valid(fail_valid), .fail_idx(fail_idx),
        .fail_golden(fail_golden), .fail_netlist(fail_netlist)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural golden instance: fixed value in reset, a mix of the stimulus otherwise.
    always_comb begin
        if (dut_rst) golden_out = RST_GOLDEN;
        else golden_out = {stim_out, ~stim_out, stim_out ^ 8'h5A, stim_out + 8'd7};
    end

    // Netlist instance = golden with a mode-dependent planted fault.
    always_comb begin
        case (mode)
            1: fault_mask = 32'hFFFF_FFFF;
            2: fault_mask = (!dut_rst && vec_idx == 16'd5) ? 32'h0000_0001 : 32'h0;
            3: fault_mask = (!dut_rst && bad_tab[stim_out]) ? 32'h0001_0000 : 32'h0;
            default: fault_mask = 32'h0;
        endcase
    end
    assign netlist_out = golden_out ^ fault_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full run from an accepted start: checks timing, every vector and the result.
    task automatic run_check(input int exp_rst_cnt, input int exp_cnt);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;              // E0
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
        for (int c = 1; c <= NV * ST + 4; c++) begin
            @(negedge clk); start = (c == 20);          // start while busy must be ignored
            @(posedge clk); #1; start = 1'b0;
            if (c < 3) chk("rst_phase_dut_rst", dut_rst, 1);
            if (c == 3) begin
                chk("dut_rst_release", dut_rst, 0);
                chk("reset_compare_cnt", mismatch_cnt, exp_rst_cnt);
                chk("stim_before_first", stim_out, 0);
            end
            if (c >= 4 && ((c - 4) % ST) == 0 && ((c - 4) / ST) < NV) begin
                chk("stim_vec", stim_out, exp_stim[(c - 4) / ST]);
                chk("vec_idx", vec_idx, (c - 4) / ST);
            end
            if (c == NV * ST + 3) begin
                chk("done_early", done, 0);
                chk("busy_before_done", busy, 1);
            end
        end
        chk("done_final", done, 1);
        chk("busy_final", busy, 0);
        chk("pass_final", pass, (exp_cnt == 0) ? 1 : 0);
        chk("mismatch_final", mismatch_cnt, exp_cnt);
        chk("vec_idx_final", vec_idx, NV - 1);
        chk("stim_hold", stim_out, exp_stim[NV - 1]);
        chk("dut_rst_done", dut_rst, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dut_rst"}, dut_rst, 1);
        chk({tag, "_stim"}, stim_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_cnt"}, mismatch_cnt, 0);
        chk({tag, "_vec_idx"}, vec_idx, 0);
    endtask

    initial begin
        logic [31:0] x;
        int rnd_cnt;

        // Reference stimulus: LFSR advanced arithmetically from seed 1.
        x = 32'h1;
        for (int k = 0; k < NV; k++) begin
            x = (x >> 1) ^ ((x & 32'h1) * TAPS);
            exp_stim[k] = x[7:0];
        end
        for (int i = 0; i < 256; i++) bad_tab[i] = ($urandom_range(0, 19) == 0);
        rnd_cnt = 0;
        for (int k = 0; k < NV; k++) rnd_cnt += bad_tab[exp_stim[k]] ? 1 : 0;

        chk("first_stim_seed1", {24'h0, exp_stim[0]}, 32'h03);

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        @(negedge clk); rst = 1'b1;

        // Equivalent pair: pass.
        mode = 0;
        run_check(0, 0);

        // Single bit-0 fault on vector 5.
        mode = 2;
        run_check(0, 1);
`ifdef CHECK_SEQ_FAIL_LOG_EN
        chk("fail_valid_v5", fail_valid, 1);
        chk("fail_idx_v5", fail_idx, 5);
        chk("fail_diff_v5", fail_golden ^ fail_netlist, 32'h1);
`endif

        // Permanently inverted netlist: reset compare plus every vector.
        mode = 1;
        run_check(1, NV + 1);
`ifdef CHECK_SEQ_FAIL_LOG_EN
        chk("fail_idx_rst", fail_idx, 16'hFFFF);
        chk("fail_golden_rst", fail_golden, RST_GOLDEN);
`endif

        // Random subset of stimulus values faulted.
        mode = 3;
        run_check(0, rnd_cnt);

        // Abort at E0+10 together with start: abort wins, counters clear.
        mode = 1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;              // E0
        repeat (9) @(posedge clk);                     // E9
        #1;
        chk("cnt_before_abort", mismatch_cnt, 3);
        @(negedge clk); abort = 1'b1; start = 1'b1;
        @(posedge clk); #1; abort = 1'b0; start = 1'b0; // E10
        chk_reset_vals("abort");
        mode = 0;
        run_check(0, 0);

        // Asynchronous reset in the middle of VEC.
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (50) @(posedge clk);
        #2; rst = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk); rst = 1'b1;
        run_check(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
